dvi_pattern_gen: RTL and testbench



---
 rtl/dvi_pattern_gen.sv | 211 +++++++++++++++++++++
 tb/tb_dvi_pattern_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_pattern_gen.sv
// Test-pattern source for the DVI output stage: colour bars, checkerboard, gradient
// and bouncing square, with a frame-synchronous pattern sequencer. Colour is 1 cycle late.
module dvi_pattern_gen #(
  parameter int X_POS_W            = 10,
  parameter int Y_POS_W            = 10,
  parameter int COLOR_W            = 8,
  parameter int H_VISIBLE          = 640,
  parameter int V_VISIBLE          = 480,
  parameter int CHECKER_LOG2       = 5,
  parameter int SQUARE_SIZE        = 32,
  parameter int SQUARE_STEP        = 2,
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic               pixel_clk_i,
  input  logic               rst_i,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  input  logic               auto_en_i,
  input  logic               next_pattern_i,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic [1:0]         pattern_o
);

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_SQUARE   = 2'd3
  } pattern_e;

  localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

  localparam logic [X_POS_W-1:0] H_VIS    = X_POS_W'(H_VISIBLE);
  localparam logic [Y_POS_W-1:0] V_VIS    = Y_POS_W'(V_VISIBLE);
  localparam logic [X_POS_W-1:0] H_LAST   = X_POS_W'(H_VISIBLE - 1);
  localparam logic [Y_POS_W-1:0] V_LAST   = Y_POS_W'(V_VISIBLE - 1);
  localparam logic [X_POS_W-1:0] BAR_W    = X_POS_W'(H_VISIBLE / 8);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [COLOR_W-1:0] FULL     = {COLOR_W{1'b1}};

  // Square arithmetic carries one guard bit so the bounce tests never wrap.
  localparam logic [X_POS_W:0] SQX_MAX  = (X_POS_W+1)'(H_VISIBLE - SQUARE_SIZE);
  localparam logic [X_POS_W:0] SQX_STEP = (X_POS_W+1)'(SQUARE_STEP);
  localparam logic [X_POS_W:0] SQX_SIZE = (X_POS_W+1)'(SQUARE_SIZE);
  localparam logic [Y_POS_W:0] SQY_MAX  = (Y_POS_W+1)'(V_VISIBLE - SQUARE_SIZE);
  localparam logic [Y_POS_W:0] SQY_STEP = (Y_POS_W+1)'(SQUARE_STEP);
  localparam logic [Y_POS_W:0] SQY_SIZE = (Y_POS_W+1)'(SQUARE_SIZE);

  pattern_e           pattern_q, pattern_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               pending_q, pending_d;
  logic [X_POS_W-1:0] sq_x_q, sq_x_d;
  logic [Y_POS_W-1:0] sq_y_q, sq_y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;

  logic               frame_tick;
  logic               advance;
  logic               visible;
  logic               in_square;
  logic               checker_white;
  logic [2:0]         bar;
  logic [X_POS_W:0]   x_ext, sq_x_ext, sq_x_sum;
  logic [Y_POS_W:0]   y_ext, sq_y_ext, sq_y_sum;

  assign frame_tick = (x_i == H_LAST) && (y_i == V_LAST);
  assign visible    = (x_i < H_VIS) && (y_i < V_VIS);
  assign bar        = 3'(x_i / BAR_W);

  assign checker_white = x_i[CHECKER_LOG2] ^ y_i[CHECKER_LOG2];

  assign x_ext    = {1'b0, x_i};
  assign y_ext    = {1'b0, y_i};
  assign sq_x_ext = {1'b0, sq_x_q};
  assign sq_y_ext = {1'b0, sq_y_q};
  assign sq_x_sum = sq_x_ext + SQX_STEP;
  assign sq_y_sum = sq_y_ext + SQY_STEP;

  assign in_square = (x_ext >= sq_x_ext) && (x_ext < sq_x_ext + SQX_SIZE) &&
                     (y_ext >= sq_y_ext) && (y_ext < sq_y_ext + SQY_SIZE);

  // A request arriving on the tick cycle itself joins that tick's advance.
  assign advance = frame_tick &&
                   (pending_q || next_pattern_i || (auto_en_i && (frame_cnt_q == CNT_LAST)));

  always_comb begin
    pattern_d   = pattern_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = pending_q;
    if (frame_tick) begin
      if (advance) begin
        pattern_d   = pattern_e'(pattern_q + 2'd1);
        frame_cnt_d = '0;
        pending_d   = 1'b0;
      end else if (auto_en_i) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end else if (next_pattern_i) begin
      pending_d = 1'b1;
    end
  end

  // dir = 0 moves towards larger coordinates, 1 towards zero.
  always_comb begin
    sq_x_d  = sq_x_q;
    sq_y_d  = sq_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (frame_tick) begin
      if (!dir_x_q) begin
        if (sq_x_sum >= SQX_MAX) begin
          sq_x_d  = SQX_MAX[X_POS_W-1:0];
          dir_x_d = 1'b1;
        end else begin
          sq_x_d = sq_x_sum[X_POS_W-1:0];
        end
      end else begin
        if (sq_x_ext <= SQX_STEP) begin
          sq_x_d  = '0;
          dir_x_d = 1'b0;
        end else begin
          sq_x_d = sq_x_q - SQX_STEP[X_POS_W-1:0];
        end
      end

      if (!dir_y_q) begin
        if (sq_y_sum >= SQY_MAX) begin
          sq_y_d  = SQY_MAX[Y_POS_W-1:0];
          dir_y_d = 1'b1;
        end else begin
          sq_y_d = sq_y_sum[Y_POS_W-1:0];
        end
      end else begin
        if (sq_y_ext <= SQY_STEP) begin
          sq_y_d  = '0;
          dir_y_d = 1'b0;
        end else begin
          sq_y_d = sq_y_q - SQY_STEP[Y_POS_W-1:0];
        end
      end
    end
  end

  // Bar order white..black falls out of the bar index bits directly.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (visible) begin
      case (pattern_q)
        PAT_BARS: begin
          red_d   = bar[1] ? '0 : FULL;
          green_d = bar[2] ? '0 : FULL;
          blue_d  = bar[0] ? '0 : FULL;
        end
        PAT_CHECKER: begin
          red_d   = checker_white ? FULL : '0;
          green_d = checker_white ? FULL : '0;
          blue_d  = checker_white ? FULL : '0;
        end
        PAT_GRADIENT: begin
          red_d   = x_i[COLOR_W-1:0];
          green_d = y_i[COLOR_W-1:0];
          blue_d  = x_i[COLOR_W-1:0] ^ y_i[COLOR_W-1:0];
        end
        default: begin
          red_d   = in_square ? FULL : '0;
          green_d = in_square ? FULL : '0;
          blue_d  = FULL;
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      pattern_q   <= PAT_BARS;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      sq_x_q      <= '0;
      sq_y_q      <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      pattern_q   <= pattern_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      sq_x_q      <= sq_x_d;
      sq_y_q      <= sq_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  assign red_o     = red_q;
  assign green_o   = green_q;
  assign blue_o    = blue_q;
  assign pattern_o = pattern_q;

endmodule

// File: tb/tb_dvi_pattern_gen.sv
// Directed bench for dvi_pattern_gen: a pattern/pixel vector table, then hand-written
// sequences for square bounce, auto-advance, queued requests and asynchronous reset.
module tb_dvi_pattern_gen;

  logic       pixel_clk_i = 1'b0;
  logic       rst_i;
  logic [9:0] x_i;
  logic [9:0] y_i;
  logic       auto_en_i;
  logic       next_pattern_i;
  logic [7:0] red_o, green_o, blue_o;
  logic [1:0] pattern_o;

  always #5 pixel_clk_i = ~pixel_clk_i;

  dvi_pattern_gen #(.FRAMES_PER_PATTERN(3)) dut (
    .pixel_clk_i    (pixel_clk_i),
    .rst_i          (rst_i),
    .x_i            (x_i),
    .y_i            (y_i),
    .auto_en_i      (auto_en_i),
    .next_pattern_i (next_pattern_i),
    .red_o          (red_o),
    .green_o        (green_o),
    .blue_o         (blue_o),
    .pattern_o      (pattern_o)
  );

  typedef struct {
    logic [1:0]  pat;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } vec_t;

  vec_t       tbl[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] exp_pat;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] BLUE  = 24'h0000FF;

  task automatic add(input logic [1:0] p, input logic [9:0] x, input logic [9:0] y,
                     input logic [23:0] rgb);
    vec_t v;
    v.pat = p; v.x = x; v.y = y; v.rgb = rgb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic np);
    x_i = x;
    y_i = y;
    next_pattern_i = np;
    @(posedge pixel_clk_i);
    #1;
    next_pattern_i = 1'b0;
  endtask

  task automatic pix(input string nm, input logic [9:0] x, input logic [9:0] y,
                     input logic [23:0] rgb);
    step(x, y, 1'b0);
    chk(nm, {red_o, green_o, blue_o}, rgb);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(10'd639, 10'd479, 1'b0);
  endtask

  task automatic adv();
    step(10'd100, 10'd10, 1'b1);
    chk("pat_hold_req", pattern_o, exp_pat);
    step(10'd639, 10'd478, 1'b0);
    chk("pat_hold_line", pattern_o, exp_pat);
    step(10'd639, 10'd479, 1'b0);
    exp_pat = exp_pat + 2'd1;
    chk("pat_adv", pattern_o, exp_pat);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic async_reset();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_rgb", {red_o, green_o, blue_o}, 24'h0);
    chk("rst_pat", pattern_o, 2'd0);
    #2 rst_i = 1'b0;
    exp_pat = 2'd0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; x_i = '0; y_i = '0; auto_en_i = 1'b0; next_pattern_i = 1'b0;
    exp_pat = 2'd0;

    add(0, 10'd0,   10'd0,   WHITE);
    add(0, 10'd79,  10'd0,   WHITE);
    add(0, 10'd80,  10'd0,   24'hFFFF00);
    add(0, 10'd160, 10'd5,   24'h00FFFF);
    add(0, 10'd240, 10'd5,   24'h00FF00);
    add(0, 10'd320, 10'd5,   24'hFF00FF);
    add(0, 10'd400, 10'd5,   24'hFF0000);
    add(0, 10'd480, 10'd5,   BLUE);
    add(0, 10'd560, 10'd5,   BLACK);
    add(0, 10'd639, 10'd0,   BLACK);
    add(0, 10'd640, 10'd0,   BLACK);
    add(0, 10'd0,   10'd480, BLACK);
    add(1, 10'd32,  10'd0,   WHITE);
    add(1, 10'd32,  10'd32,  BLACK);
    add(1, 10'd0,   10'd0,   BLACK);
    add(1, 10'd31,  10'd31,  BLACK);
    add(1, 10'd64,  10'd32,  WHITE);
    add(1, 10'd700, 10'd32,  BLACK);
    add(2, 10'd300, 10'd200, 24'h2CC8E4);
    add(2, 10'd0,   10'd0,   BLACK);
    add(2, 10'd255, 10'd1,   24'hFF01FE);
    add(2, 10'd256, 10'd128, 24'h008080);
    add(2, 10'd639, 10'd478, 24'h7FDEA1);
    add(2, 10'd800, 10'd10,  BLACK);
    // three advances precede these, so the square sits at (6,6)
    add(3, 10'd6,   10'd6,   WHITE);
    add(3, 10'd5,   10'd6,   BLUE);
    add(3, 10'd6,   10'd5,   BLUE);
    add(3, 10'd37,  10'd37,  WHITE);
    add(3, 10'd38,  10'd6,   BLUE);
    add(3, 10'd6,   10'd38,  BLUE);
    add(3, 10'd700, 10'd6,   BLACK);

    repeat (3) @(posedge pixel_clk_i);
    #1;
    chk("reset_rgb", {red_o, green_o, blue_o}, 24'h0);
    chk("reset_pat", pattern_o, 2'd0);
    rst_i = 1'b0;

    foreach (tbl[i]) begin
      while (exp_pat != tbl[i].pat) adv();
      pix($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].rgb);
    end

    // Square: 3 ticks so far; tick 224 puts it at (448,448) with y at its limit.
    ticks(221);
    pix("sq224_in",    10'd448, 10'd448, WHITE);
    pix("sq224_left",  10'd447, 10'd448, BLUE);
    pix("sq224_bot",   10'd448, 10'd479, WHITE);
    pix("sq224_right", 10'd480, 10'd448, BLUE);
    pix("sq224_redge", 10'd479, 10'd448, WHITE);
    ticks(1);
    pix("sq225_in",    10'd450, 10'd446, WHITE);
    pix("sq225_left",  10'd449, 10'd446, BLUE);
    pix("sq225_top",   10'd450, 10'd445, BLUE);
    ticks(79);
    pix("sq304_in",    10'd608, 10'd288, WHITE);
    pix("sq304_left",  10'd607, 10'd288, BLUE);
    pix("sq304_far",   10'd639, 10'd319, WHITE);
    pix("sq304_below", 10'd608, 10'd320, BLUE);
    ticks(1);
    pix("sq305_in",    10'd606, 10'd286, WHITE);
    pix("sq305_right", 10'd638, 10'd286, BLUE);
    pix("sq305_redge", 10'd637, 10'd286, WHITE);
    chk("sq_pat_stays", pattern_o, 2'd3);

    // Auto-advance with a coincident request on the third tick: one step, 3 wraps to 0.
    auto_en_i = 1'b1;
    ticks(2);
    chk("auto_before", pattern_o, 2'd3);
    step(10'd639, 10'd479, 1'b1);
    chk("auto_coinc_wrap", pattern_o, 2'd0);
    ticks(2);
    chk("auto_cnt_cleared", pattern_o, 2'd0);
    ticks(1);
    chk("auto_next", pattern_o, 2'd1);
    ticks(1);
    auto_en_i = 1'b0;
    ticks(5);
    chk("auto_frozen", pattern_o, 2'd1);
    auto_en_i = 1'b1;
    ticks(1);
    chk("auto_resume_hold", pattern_o, 2'd1);
    ticks(1);
    chk("auto_resume_adv", pattern_o, 2'd2);
    auto_en_i = 1'b0;

    // Two requests before a tick queue only one advance.
    step(10'd50, 10'd50, 1'b1);
    step(10'd60, 10'd50, 1'b1);
    chk("queued_wait", pattern_o, 2'd2);
    ticks(1);
    chk("queued_adv", pattern_o, 2'd3);
    ticks(1);
    chk("queued_once", pattern_o, 2'd3);

    // Clean start, then 50 ticks (2 of them advances) leaves pattern 2, square at (100,100).
    async_reset();
    ticks(48);
    adv();
    adv();
    pix("pre_rst_grad", 10'd300, 10'd200, 24'h2CC8E4);
    async_reset();
    adv();
    adv();
    adv();
    pix("post_rst_sq",    10'd6,   10'd6,   WHITE);
    pix("post_rst_left",  10'd5,   10'd6,   BLUE);
    pix("post_rst_stale", 10'd106, 10'd106, BLUE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
